boot_loader: RTL
================

# boot_loader

Program loader that sequences `cpuCore` bring-up. It holds the core in reset and accepts instruction words on a valid/ready stream. Each word is written into instruction memory through the core's debug write port (`dbg_wr_en`/`dbg_addr`/`dbg_instr`) with fixed setup and hold spacing. After the last word it releases core reset. It sits between the host/boot stream and `cpuCore`, and replaces hand-sequenced debug writes.

## Interface
- XLEN, 32, data and address width
- CNT_W, 16, width of the word counter
- SETUP_CYCLES, 2, cycles that `dbg_addr`/`dbg_instr` are stable before `dbg_wr_en` pulses (≥1)
- RELEASE_CYCLES, 1, cycles between the final hold cycle and `core_rst` deassertion (≥1)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  single-cycle pulse that begins a load session
- base_addr  in  XLEN  byte address of the first word; sampled on `start`
- word_count  in  CNT_W  number of words to load; sampled on `start`
- s_valid  in  1  stream word valid
- s_ready  out  1  loader can accept a word
- s_data  in  XLEN  instruction word
- dbg_wr_en  out  1  debug write strobe to `cpuCore`
- dbg_addr  out  XLEN  debug write address
- dbg_instr  out  XLEN  debug write data
- core_rst  out  1  active-high reset to `cpuCore`
- busy  out  1  load session in progress
- done  out  1  core released; held high until the next accepted `start`
- err  out  1  sticky, set when `start` is rejected

## Operation
- States: IDLE, ACCEPT, SETUP, WRITE, HOLD, RELEASE, RUN.
- Reset (rst=0, asynchronous):
  - state=IDLE, dbg_wr_en=0, dbg_addr=0, dbg_instr=0, core_rst=1.
  - s_ready=0, busy=0, done=0, err=0, counters=0.
- IDLE or RUN with `start=1`:
  - If base_addr[1:0]≠0: set err, stay in the current state, change no other output.
  - Otherwise: latch addr=base_addr and cnt=word_count, clear done and err, set core_rst=1 and busy=1.
  - Next state is ACCEPT if cnt≠0, else RELEASE.
- `start` in any other state is ignored. It does not set err.
- ACCEPT:
  - s_ready=1.
  - On s_valid&&s_ready: register dbg_addr=addr and dbg_instr=s_data, then go to SETUP.
- SETUP: lasts exactly SETUP_CYCLES cycles with dbg_wr_en=0, then goes to WRITE.
- WRITE: exactly 1 cycle with dbg_wr_en=1.
- HOLD:
  - Exactly 1 cycle with dbg_wr_en=0; dbg_addr/dbg_instr unchanged.
  - addr←addr+4, wrapping modulo 2^XLEN. cnt←cnt−1.
  - Next state is ACCEPT if the new cnt≠0, else RELEASE.
- RELEASE: RELEASE_CYCLES cycles with core_rst=1, then go to RUN.
- RUN: core_rst=0, busy=0, done=1.
- dbg_addr and dbg_instr keep their last written values outside a transfer.
- s_ready is 0 in every state except ACCEPT.

## Timing
- All outputs are registered. No combinational path from input to output.
- Handshake in cycle T:
  - dbg_addr/dbg_instr are valid from T+1.
  - dbg_wr_en is high in cycle T+1+SETUP_CYCLES.
  - HOLD is cycle T+2+SETUP_CYCLES.
  - s_ready is high again at T+3+SETUP_CYCLES.
- Minimum word period is SETUP_CYCLES+3 cycles (5 at the defaults).
- s_valid low in ACCEPT: wait indefinitely with no timeout. s_data is ignored when no handshake occurs.
- Accepted `start` in cycle S:
  - core_rst and busy are high from S+1.
  - With word_count=0: core_rst falls and done rises at S+1+RELEASE_CYCLES.
- Last HOLD in cycle H: core_rst=0 and done=1 from H+1+RELEASE_CYCLES.
- `start` in RUN re-asserts core_rst from the next cycle; the core is re-held for reload.
- rst asserted mid-transfer, including during WRITE: dbg_wr_en drops immediately (asynchronous) and core_rst goes to 1. No partial retry occurs after rst releases.

## Test plan
- Single word:
  - Stimulus: start with base=4, count=1; s_data={1'b0,10'd12,1'b0,8'd0,5'd2,7'b1101111} offered at the first s_ready.
  - Required: dbg_addr=4 and dbg_instr equal to that word, stable for 2 cycles before dbg_wr_en. dbg_wr_en is high for 1 cycle, then 1 hold cycle. core_rst falls 1 cycle after HOLD; done=1.
- Three-word burst:
  - Stimulus: base=8, count=3; s_valid held high with data 0xA, 0xB, 0xC.
  - Required: writes to 8/12/16 with data A/B/C; dbg_wr_en pulses 5 cycles apart; core_rst=1 throughout until release.
- Stalls and zero count:
  - Stimulus: s_valid dropped for 7 cycles between words.
  - Required: s_ready stays high, no spurious dbg_wr_en, and the address sequence is unchanged.
  - Stimulus: count=0.
  - Required: no writes; core_rst releases at S+2.
- Rejection and wrap:
  - Stimulus: start with base=6.
  - Required: err=1, state IDLE, core_rst=1, no writes.
  - Stimulus: a valid start with base=0xFFFFFFFC, count=2.
  - Required: err clears; writes go to 0xFFFFFFFC then 0x00000000.
- Reset and reload:
  - Stimulus: rst=0 during WRITE.
  - Required: all outputs at their reset values immediately.
  - Stimulus: start issued in RUN.
  - Required: core_rst=1 and done=0 next cycle, and the new load completes normally.
  - Stimulus: start issued in SETUP.
  - Required: ignored, err stays 0.

Source files
------------

// File: rtl/boot_loader.sv
// Boot loader: holds cpuCore in reset, streams instruction words into its debug
// write port with fixed setup/hold spacing, then releases the core.
module boot_loader #(
  parameter int XLEN           = 32,
  parameter int CNT_W          = 16,
  parameter int SETUP_CYCLES   = 2,
  parameter int RELEASE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [XLEN-1:0]  base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [XLEN-1:0]  s_data,
  output logic             dbg_wr_en,
  output logic [XLEN-1:0]  dbg_addr,
  output logic [XLEN-1:0]  dbg_instr,
  output logic             core_rst,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int TMR_MAX = (SETUP_CYCLES > RELEASE_CYCLES) ? SETUP_CYCLES : RELEASE_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'(SETUP_CYCLES - 1);
  localparam logic [TMR_W-1:0] REL_LOAD   = TMR_W'(RELEASE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ACCEPT, SETUP, WRITE, HOLD, RELEASE, RUN} state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [XLEN-1:0]  dbg_addr_q, dbg_addr_d, dbg_instr_q, dbg_instr_d;
  logic             s_ready_q, s_ready_d, dbg_wr_en_q, dbg_wr_en_d;
  logic             core_rst_q, core_rst_d, busy_q, busy_d;
  logic             done_q, done_d, err_q, err_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    tmr_d       = tmr_q;
    dbg_addr_d  = dbg_addr_q;
    dbg_instr_d = dbg_instr_q;
    core_rst_d  = core_rst_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    case (state_q)
      IDLE, RUN: begin
        if (start) begin
          // A misaligned base only flags err; the running core is left alone.
          if (base_addr[1:0] != 2'b00) begin
            err_d = 1'b1;
          end else begin
            addr_d     = base_addr;
            cnt_d      = word_count;
            done_d     = 1'b0;
            err_d      = 1'b0;
            core_rst_d = 1'b1;
            busy_d     = 1'b1;
            if (word_count != '0) begin
              state_d = ACCEPT;
            end else begin
              state_d = RELEASE;
              tmr_d   = REL_LOAD;
            end
          end
        end
      end
      ACCEPT: begin
        if (s_valid && s_ready_q) begin
          dbg_addr_d  = addr_q;
          dbg_instr_d = s_data;
          tmr_d       = SETUP_LOAD;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        if (tmr_q == '0) state_d = WRITE;
        else             tmr_d   = tmr_q - TMR_W'(1);
      end
      WRITE: state_d = HOLD;
      HOLD: begin
        addr_d = addr_q + XLEN'(4);
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q != CNT_W'(1)) begin
          state_d = ACCEPT;
        end else begin
          state_d = RELEASE;
          tmr_d   = REL_LOAD;
        end
      end
      RELEASE: begin
        if (tmr_q == '0) begin
          state_d    = RUN;
          core_rst_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Strobes are registered from the next state so they align with it.
    s_ready_d   = (state_d == ACCEPT);
    dbg_wr_en_d = (state_d == WRITE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      tmr_q       <= '0;
      dbg_addr_q  <= '0;
      dbg_instr_q <= '0;
      s_ready_q   <= 1'b0;
      dbg_wr_en_q <= 1'b0;
      core_rst_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      dbg_addr_q  <= dbg_addr_d;
      dbg_instr_q <= dbg_instr_d;
      s_ready_q   <= s_ready_d;
      dbg_wr_en_q <= dbg_wr_en_d;
      core_rst_q  <= core_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign dbg_wr_en = dbg_wr_en_q;
  assign dbg_addr  = dbg_addr_q;
  assign dbg_instr = dbg_instr_q;
  assign core_rst  = core_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
endmodule
